// File: rtl/tt_sweep_sequencer.sv
// tt_sweep_sequencer: walks a 3-input combinational circuit through its 8
// input rows, majority-samples the synchronized output for each row and
// assembles the measured truth table (row r lands in bit 7-r).
// Build option: define TT_SWEEP_GRAY_EN to visit rows in Gray order so only
// one circuit input toggles per row; default build visits rows in binary order.
module tt_sweep_sequencer #(
    parameter int          SETTLE_CYCLES = 4,
    parameter int          SAMPLES       = 3,
    parameter logic [7:0]  EXPECTED_TT   = 8'h41
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    input  logic       dut_out,
    output logic [7:0] tt_out,
    output logic       done,
    output logic       match,
    output logic       unstable
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, STORE, FIN} state_t;

    state_t     state, state_nxt;
    logic [1:0] sync;        // sync[1] is the only copy of dut_out used
    logic [2:0] step;        // sweep position 0..7
    logic [2:0] row;         // input vector for the current step
    logic [7:0] cnt;         // shared settle / sample down-counter
    logic [2:0] ones;
    logic       first;
    logic       disagree;
    logic [7:0] work;
    logic       unst_work;

`ifdef TT_SWEEP_GRAY_EN
    assign row = step ^ {1'b0, step[2:1]};
`else
    assign row = step;
`endif

    // two-flop synchronizer for the asynchronous circuit output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], dut_out};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (cnt == 8'd0) state_nxt = SAMPLE;
            SAMPLE:  if (cnt == 8'd0) state_nxt = STORE;
            STORE:   state_nxt = (step == 3'd7) ? FIN : APPLY;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: inputs are only driven while a row is in flight
    always_comb begin
        busy = (state == APPLY) || (state == SETTLE) ||
               (state == SAMPLE) || (state == STORE);
        {dut_in1, dut_in2, dut_in3} = busy ? row : 3'b000;
    end

    // per-row counting, voting and table assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= '0;
            cnt       <= '0;
            ones      <= '0;
            first     <= 1'b0;
            disagree  <= 1'b0;
            work      <= '0;
            unst_work <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    step      <= '0;
                    work      <= '0;
                    unst_work <= 1'b0;
                end
                APPLY: begin
                    cnt      <= 8'(SETTLE_CYCLES - 1);
                    ones     <= '0;
                    disagree <= 1'b0;
                end
                SETTLE: cnt <= (cnt == 8'd0) ? 8'(SAMPLES - 1) : cnt - 8'd1;
                SAMPLE: begin
                    cnt  <= cnt - 8'd1;
                    ones <= ones + {2'b00, sync[1]};
                    if (cnt == 8'(SAMPLES - 1)) first <= sync[1];
                    else if (sync[1] != first) disagree <= 1'b1;
                end
                STORE: begin
                    work[3'd7 - row] <= (ones > 3'(SAMPLES / 2));
                    unst_work        <= unst_work | disagree;
                    // the last row leaves step at 7; only FIN wraps it
                    if (step != 3'd7) step <= step + 3'd1;
                end
                FIN: step <= '0;
                default: ;
            endcase
        end
    end

    // result registers: updated only when a sweep completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_out   <= '0;
            match    <= 1'b0;
            unstable <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (state == FIN) begin
                tt_out   <= work;
                match    <= (work == EXPECTED_TT);
                unstable <= unst_work;
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_sequencer.sv
// Bench for tt_sweep_sequencer: two instances (defaults, and a slow one with
// SETTLE_CYCLES=10 / SAMPLES=5) each driving a behavioural circuit model that
// can be an arbitrary truth table, delayed by 6 cycles, or glitched for one
// cycle inside the sampling window of a chosen row.
module tb_tt_sweep_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       start = '0;
    logic [1:0]       busy, done, match, unst, cout;
    logic [1:0][2:0]  din;
    logic [1:0][7:0]  tt;

    // circuit model controls
    logic [1:0][7:0]      func;
    logic [1:0]           dly_en, inj_en;
    logic [1:0][2:0]      inj_row;
    int                   inj_k [2];
    logic [1:0][5:0][2:0] pipe;
    int                   rcnt [2];
    logic [1:0][2:0]      reff;

    int n_chk  = 0;
    int n_fail = 0;

    tt_sweep_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]),
        .dut_in1(din[0][2]), .dut_in2(din[0][1]), .dut_in3(din[0][0]),
        .dut_out(cout[0]), .tt_out(tt[0]), .done(done[0]),
        .match(match[0]), .unstable(unst[0])
    );

    tt_sweep_sequencer #(.SETTLE_CYCLES(10), .SAMPLES(5), .EXPECTED_TT(8'h41)) u_slow (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]),
        .dut_in1(din[1][2]), .dut_in2(din[1][1]), .dut_in3(din[1][0]),
        .dut_out(cout[1]), .tt_out(tt[1]), .done(done[1]),
        .match(match[1]), .unstable(unst[1])
    );

    // delay line of applied inputs and cycles spent on the current row
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            pipe[u] <= {pipe[u][4:0], din[u]};
            rcnt[u] <= (busy[u] && din[u] == inj_row[u]) ? rcnt[u] + 1 : 0;
        end
    end

    // circuit output: truth-table lookup, optionally delayed and glitched
    always_comb begin
        reff = '0;
        cout = '0;
        for (int u = 0; u < 2; u++) begin
            reff[u] = dly_en[u] ? pipe[u][5] : din[u];
            cout[u] = func[u][3'd7 - reff[u]];
            if (inj_en[u] && busy[u] && din[u] == inj_row[u] && rcnt[u] == inj_k[u])
                cout[u] = ~cout[u];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_row(input int i);
`ifdef TT_SWEEP_GRAY_EN
        return 3'(i ^ (i >> 1));
`else
        return 3'(i);
`endif
    endfunction

    // one full sweep on instance u; hold = cycles start stays high past the start edge
    task automatic sweep(input int u, input logic [7:0] etf, input logic eunst,
                         input int hold, input bit exact);
        int T, lat, done_at, done_cnt, busy_cnt, toggles;
        logic [7:0]  tt_prev;
        logic [23:0] ord, ord_exp;
        bit row_moved, tt_moved;
        T = (u == 0) ? 9 : 17;
        lat = 8 * T + 1;
        done_at = -1; done_cnt = 0; busy_cnt = 0; toggles = 0;
        row_moved = 0; tt_moved = 0;
        ord = '0; ord_exp = '0;
        tt_prev = tt[u];
        @(negedge clk); start[u] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= lat + 2; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (c == hold) start[u] = 1'b0;
            if (busy[u]) busy_cnt++;
            if (done[u]) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c < 8 * T) begin
                if (c % T == 0) ord[(c / T) * 3 +: 3] = din[u];
                else if (din[u] != ord[(c / T) * 3 +: 3]) row_moved = 1;
            end
            if (c < lat && tt[u] !== tt_prev) tt_moved = 1;
        end
        for (int i = 0; i < 8; i++) begin
            ord_exp[i * 3 +: 3] = exp_row(i);
            if (i > 0 && $countones(ord[i * 3 +: 3] ^ ord[(i - 1) * 3 +: 3]) > 1) toggles++;
        end
        chk("latency", done_at, lat);
        chk("done_width", done_cnt, 1);
        chk("busy_cycles", busy_cnt, 8 * T);
        chk("row_order", ord, ord_exp);
        chk("row_stable", row_moved, 0);
        chk("tt_held", tt_moved, 0);
        chk("din_idle", din[u], 0);
`ifdef TT_SWEEP_GRAY_EN
        chk("gray_toggles", toggles, 0);
`endif
        if (exact) begin
            chk("tt_out", tt[u], etf);
            chk("match", match[u], etf == 8'h41);
            chk("unstable", unst[u], eunst);
        end else begin
            chk("tt_wrong", tt[u] != 8'h41, 1);
        end
    endtask

    initial begin
        func = '0; dly_en = '0; inj_en = '0; inj_row = '0; pipe = '0;
        inj_k[0] = 0; inj_k[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tt", tt[0], 0);
        chk("rst_flags", {match[0], unst[0], busy[0], done[0]}, 0);
        chk("rst_din", din[0], 0);
        rst_n = 1'b1;

        // reference circuit in3 & ~(in1^in2)
        func[0] = 8'h41;
        sweep(0, 8'h41, 1'b0, 0, 1);
        // stuck-at-1, then back to the correct circuit
        func[0] = 8'hFF;
        sweep(0, 8'hFF, 1'b0, 0, 1);
        func[0] = 8'h41;
        sweep(0, 8'h41, 1'b0, 20, 1);
        // single flipped sample on row 111: majority holds, flagged unstable
        inj_en[0] = 1'b1; inj_row[0] = 3'b111; inj_k[0] = 5;
        sweep(0, 8'h41, 1'b1, 0, 1);
        inj_en[0] = 1'b0;
        // 6-cycle circuit delay is too slow for a 4-cycle settle
        dly_en[0] = 1'b1;
        sweep(0, 8'h41, 1'b0, 0, 0);
        dly_en[0] = 1'b0;

        // randomized truth tables and glitches
        for (int it = 0; it < 6; it++) begin
            func[0]    = (it % 3 == 0) ? 8'h41 : 8'($urandom);
            inj_en[0]  = 1'($urandom);
            inj_row[0] = 3'($urandom);
            inj_k[0]   = 4 + int'($urandom_range(0, 2));
            sweep(0, func[0], inj_en[0], 0, 1);
        end
        inj_en[0] = 1'b0;

        // slow instance with the delayed circuit: settle window is long enough
        dly_en[1] = 1'b1;
        for (int it = 0; it < 3; it++) begin
            func[1]    = (it == 0) ? 8'h41 : 8'($urandom);
            inj_en[1]  = (it == 2);
            inj_row[1] = 3'($urandom);
            inj_k[1]   = 10 + int'($urandom_range(0, 4));
            sweep(1, func[1], inj_en[1], 0, 1);
        end

        // reset 30 cycles into a sweep
        func[0] = 8'h41;
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); start[0] = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tt", tt[0], 0);
        chk("midrst_flags", {match[0], unst[0], busy[0], done[0]}, 0);
        chk("midrst_din", din[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (done[0] || busy[0]) seen++;
            end
            chk("midrst_quiet", seen, 0);
        end
        sweep(0, 8'h41, 1'b0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
